// File: rtl/disp_sched_if.sv
// Display scheduler bus: control inputs from the
// entry/alarm logic and page/digit outputs to the 7-seg mux.
interface disp_sched_if;
  logic       entry_active;
  logic [1:0] entry_digit;
  logic [1:0] alarm;
  logic       hold;
  logic [1:0] page;
  logic       page_start;
  logic [3:0] dig_en;

  modport master (
    output entry_active, entry_digit, alarm, hold,
    input  page, page_start, dig_en
  );

  modport slave (
    input  entry_active, entry_digit, alarm, hold,
    output page, page_start, dig_en
  );
endinterface

// File: rtl/disp_sched.sv
// Display page scheduler: TEMP/DELTA/STATE rotation with
// entry and emergency preemption, plus entry-digit blink.
module disp_sched #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DWELL_TICKS = 1,
  parameter int BLINK_DIV   = 6_250_000
) (
  input logic         clk,
  input logic         rst_n,
  disp_sched_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    PG_TEMP  = 2'd0,
    PG_DELTA = 2'd1,
    PG_STATE = 2'd2,
    PG_ENTRY = 2'd3
  } page_e;

  page_e         page_q, page_d;
  logic          ps_q, ps_d;
  logic          frc_q, frc_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dwl_q, dwl_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          ph_q, ph_d;
  logic [1:0]    dig_q, dig_d;
  logic          tick;
  logic          emerg;
  logic          bwrap;
  logic [3:0]    den;

  assign tick  = (pre_q == PMAX);
  assign bwrap = (blk_q == BMAX);
  assign emerg = bus.alarm[1];

  // State register for page, pulse, counters and blink
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page_q <= PG_TEMP;
      ps_q   <= 1'b0;
      frc_q  <= 1'b0;
      pre_q  <= '0;
      dwl_q  <= '0;
      blk_q  <= '0;
      ph_q   <= 1'b1;
      dig_q  <= 2'd3;
    end else begin
      page_q <= page_d;
      ps_q   <= ps_d;
      frc_q  <= frc_d;
      pre_q  <= pre_d;
      dwl_q  <= dwl_d;
      blk_q  <= blk_d;
      ph_q   <= ph_d;
      dig_q  <= dig_d;
    end
  end

  // Next page by priority: entry, emergency, exit, dwell
  always_comb begin
    page_d = page_q;
    frc_d  = frc_q;
    pre_d  = tick ? '0 : pre_q + 1'b1;
    dwl_d  = dwl_q;
    blk_d  = bwrap ? '0 : blk_q + 1'b1;
    ph_d   = bwrap ? ~ph_q : ph_q;
    dig_d  = bus.entry_digit;
    if (bus.entry_active) begin
      page_d = PG_ENTRY;
      frc_d  = 1'b0;
      dwl_d  = '0;
    end else if (emerg) begin
      page_d = PG_STATE;
      frc_d  = 1'b1;
      dwl_d  = '0;
    end else if (page_q == PG_ENTRY || frc_q) begin
      page_d = PG_TEMP;
      frc_d  = 1'b0;
      pre_d  = '0;
      dwl_d  = '0;
    end else if (tick && !bus.hold) begin
      if (dwl_q == DMAX) begin
        dwl_d = '0;
        unique case (page_q)
          PG_TEMP:  page_d = PG_DELTA;
          PG_DELTA: page_d = PG_STATE;
          default:  page_d = PG_TEMP;
        endcase
      end else begin
        dwl_d = dwl_q + 1'b1;
      end
    end
    // Each new digit (or fresh entry) starts lit
    if ((page_d == PG_ENTRY && page_q != PG_ENTRY) ||
        bus.entry_digit != dig_q) begin
      blk_d = '0;
      ph_d  = 1'b1;
    end
    ps_d = (page_d != page_q);
  end

  // Digit enables: only the entered digit blinks
  always_comb begin
    den = 4'b1111;
    if (page_q == PG_ENTRY && dig_q != 2'd3)
      den[dig_q] = ph_q;
  end

  assign bus.page       = page_q;
  assign bus.page_start = ps_q;
  assign bus.dig_en     = den;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with short dividers
// (TICK_DIV=4, DWELL_TICKS=2, BLINK_DIV=3).
module tb_disp_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  disp_sched_if bus ();

  disp_sched #(
    .TICK_DIV   (4),
    .DWELL_TICKS(2),
    .BLINK_DIV  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    bus.entry_active = 1'b0;
    bus.entry_digit  = 2'd0;
    bus.alarm        = 2'd0;
    bus.hold         = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic rotation(input string t);
    logic [1:0] ep;
    logic       es;
    for (int c = 0; c <= 24; c++) begin
      adv_to(c);
      ep = (c < 8) ? 2'd0 : (c < 16) ? 2'd1 : (c < 24) ? 2'd2 : 2'd0;
      es = (c == 8 || c == 16 || c == 24);
      chk({t, "_page"}, {2'b00, bus.page}, {2'b00, ep});
      chk({t, "_ps"}, {3'b000, bus.page_start}, {3'b000, es});
      chk({t, "_dig"}, bus.dig_en, 4'hf);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // Test 1: idle rotation from reset
    do_reset();
    rotation("rot");

    // Test 2: hold on DELTA, alarm=1 has no effect
    do_reset();
    bus.alarm = 2'd1;
    adv_to(10);
    bus.hold = 1'b1;
    for (int c = 10; c <= 35; c++) begin
      adv_to(c);
      if (c == 30) bus.hold = 1'b0;
      chk("hold_page", {2'b00, bus.page}, 4'd1);
      chk("hold_ps", {3'b000, bus.page_start}, 4'd0);
    end
    adv_to(36);
    chk("hold_rel_page", {2'b00, bus.page}, 4'd2);
    chk("hold_rel_ps", {3'b000, bus.page_start}, 4'd1);

    // Test 3: entry on digit 1, blink 3 on / 3 off
    do_reset();
    adv_to(2);
    bus.entry_active = 1'b1;
    bus.entry_digit  = 2'd1;
    adv_to(3);
    chk("ent_page", {2'b00, bus.page}, 4'd3);
    chk("ent_ps", {3'b000, bus.page_start}, 4'd1);
    for (int c = 3; c <= 13; c++) begin
      adv_to(c);
      chk("ent_blink", bus.dig_en,
          (((c - 3) / 3) % 2 == 1) ? 4'hd : 4'hf);
      if (c == 4) chk("ent_ps_once", {3'b000, bus.page_start}, 4'd0);
    end

    // Test 4: digit change restarts blink, exit to TEMP
    bus.entry_digit = 2'd2;
    for (int c = 14; c <= 19; c++) begin
      adv_to(c);
      chk("dig2_blink", bus.dig_en, (c < 17) ? 4'hf : 4'hb);
    end
    adv_to(20);
    bus.entry_active = 1'b0;
    adv_to(21);
    chk("exit_page", {2'b00, bus.page}, 4'd0);
    chk("exit_ps", {3'b000, bus.page_start}, 4'd1);
    chk("exit_dig", bus.dig_en, 4'hf);
    adv_to(28);
    chk("exit_dwell_page", {2'b00, bus.page}, 4'd0);
    adv_to(29);
    chk("exit_delta_page", {2'b00, bus.page}, 4'd1);
    chk("exit_delta_ps", {3'b000, bus.page_start}, 4'd1);

    // Test 5: emergency forces STATE, then entry overrides
    do_reset();
    adv_to(2);
    bus.alarm = 2'd2;
    adv_to(3);
    chk("alm_page", {2'b00, bus.page}, 4'd2);
    chk("alm_ps", {3'b000, bus.page_start}, 4'd1);
    for (int c = 4; c <= 43; c++) begin
      adv_to(c);
      chk("alm_hold_page", {2'b00, bus.page}, 4'd2);
      chk("alm_hold_ps", {3'b000, bus.page_start}, 4'd0);
    end
    bus.alarm = 2'd0;
    adv_to(44);
    chk("alm_exit_page", {2'b00, bus.page}, 4'd0);
    chk("alm_exit_ps", {3'b000, bus.page_start}, 4'd1);
    adv_to(51);
    chk("alm_dwell_page", {2'b00, bus.page}, 4'd0);
    adv_to(52);
    chk("alm_delta_page", {2'b00, bus.page}, 4'd1);
    adv_to(53);
    bus.alarm = 2'd3;
    adv_to(54);
    chk("alm3_page", {2'b00, bus.page}, 4'd2);
    adv_to(56);
    bus.entry_active = 1'b1;
    bus.entry_digit  = 2'd3;
    adv_to(57);
    chk("alm_ent_page", {2'b00, bus.page}, 4'd3);
    chk("alm_ent_ps", {3'b000, bus.page_start}, 4'd1);
    chk("alm_ent_dig3", bus.dig_en, 4'hf);
    adv_to(60);
    bus.entry_active = 1'b0;
    bus.alarm        = 2'd0;
    adv_to(61);
    chk("alm_ent_exit", {2'b00, bus.page}, 4'd0);

    // Test 6: reset during blink-off of digit 0
    do_reset();
    adv_to(1);
    bus.entry_active = 1'b1;
    bus.entry_digit  = 2'd0;
    adv_to(2);
    chk("r6_page", {2'b00, bus.page}, 4'd3);
    adv_to(5);
    chk("r6_off", bus.dig_en, 4'he);
    do_reset();
    rotation("r6rot");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
